// File: rtl/dbus_cbus_bridge.sv
// Uncached single-beat bridge: latches one dbus request, issues one cbus transaction,
// and returns one registered dbus response.
module dbus_cbus_bridge #(
    parameter int unsigned ALIGN_CHECK = 1,
    parameter int unsigned MAX_BEATS   = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [139:0] dreq,
    output logic [65:0]  dresp,
    output logic [150:0] creq,
    input  logic [65:0]  cresp,
    output logic         busy_o,
    output logic         misal_o,
    output logic         err_o
);

    localparam logic [2:0] MSIZE2          = 3'd1;
    localparam logic [2:0] MSIZE4          = 3'd2;
    localparam logic [2:0] MSIZE8          = 3'd3;
    localparam logic [7:0] MLEN1           = 8'd0;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [7:0] MAX_B           = 8'(MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        w_dvalid;
    logic [63:0] w_daddr;
    logic [2:0]  w_dsize;
    logic [7:0]  w_dstrb;
    logic [63:0] w_ddata;
    logic        w_cready;
    logic        w_clast;
    logic [63:0] w_cdata;
    logic        w_misal;
    logic        w_reject;

    logic [63:0] r_addr;
    logic [2:0]  r_size;
    logic [7:0]  r_strb;
    logic [63:0] r_data;
    logic [63:0] r_rdata;
    logic [7:0]  r_beat;
    logic        r_misal;
    logic        r_err;

    // dbus_req_t = {valid, addr, size, strobe, data}; cbus_resp_t = {ready, last, data}
    assign w_dvalid = dreq[139];
    assign w_daddr  = dreq[138:75];
    assign w_dsize  = dreq[74:72];
    assign w_dstrb  = dreq[71:64];
    assign w_ddata  = dreq[63:0];
    assign w_cready = cresp[65];
    assign w_clast  = cresp[64];
    assign w_cdata  = cresp[63:0];

    always_comb begin
        w_misal = 1'b0;
        case (w_dsize)
            MSIZE2:  w_misal = w_daddr[0] != 1'b0;
            MSIZE4:  w_misal = w_daddr[1:0] != 2'b00;
            MSIZE8:  w_misal = w_daddr[2:0] != 3'b000;
            default: w_misal = 1'b0;
        endcase
    end

    assign w_reject = (ALIGN_CHECK != 0) && w_misal;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_dvalid) w_next = w_reject ? S_DONE : S_REQ;
            S_REQ:  if (w_cready && w_clast) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_strb  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
            r_beat  <= '0;
            r_misal <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dvalid) begin
                        r_addr  <= w_daddr;
                        r_size  <= w_dsize;
                        r_strb  <= w_dstrb;
                        r_data  <= w_ddata;
                        r_rdata <= '0;
                        r_beat  <= '0;
                        if (w_reject) r_misal <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_cready) begin
                        if (w_clast) begin
                            // Writes keep rdata at zero so the response carries no data.
                            if (r_strb == '0) r_rdata <= w_cdata;
                        end else begin
                            if (r_beat >= MAX_B) r_err <= 1'b1;
                            if (r_beat != '1) r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // cbus_req_t = {valid, is_write, size, addr, strobe, data, len, burst}
    assign creq    = (r_state == S_REQ)
                   ? {1'b1, |r_strb, r_size, r_addr, r_strb, r_data, MLEN1, AXI_BURST_FIXED}
                   : '0;
    assign dresp   = (r_state == S_DONE) ? {2'b11, r_rdata} : '0;
    assign busy_o  = r_state != S_IDLE;
    assign misal_o = r_misal;
    assign err_o   = r_err;

endmodule
